usb_rx_timer: RTL and testbench

Bit-timing unit for the USB receive path, mirroring the transmitter-side timer. It recovers bit timing from line transitions reported by the edge detector and produces a mid-bit sample strobe for the shift register. It counts de-stuffed data bits, flags each completed byte to the receive controller, and flags loss of line activity.

---
 rtl/usb_rx_pkg.sv | 15 +
 rtl/rx_rollover_counter.sv | 36 +++
 rtl/usb_rx_timer.sv | 98 +++++++++
 tb/tb_usb_rx_timer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared constants and sizing helpers for the USB receive bit-timing path.
package usb_rx_pkg;

  localparam int unsigned BITS_PER_BYTE    = 8;
  localparam int unsigned DEF_CLKS_PER_BIT = 8;
  localparam int unsigned DEF_SAMPLE_POINT = 3;
  localparam int unsigned DEF_IDLE_BITS    = 8;

  // One spare bit lets the idle counter park one past its firing value.
  function automatic int unsigned idle_cnt_width(int unsigned idle_bits,
                                                 int unsigned clks_per_bit);
    return $clog2(idle_bits * clks_per_bit) + 1;
  endfunction

endpackage

// File: rtl/rx_rollover_counter.sv
// Up-counter that wraps to zero after reaching a run-time rollover value.
module rx_rollover_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear_i,
  input  logic             count_enable_i,
  input  logic [Width-1:0] rollover_val_i,
  output logic [Width-1:0] count_o,
  output logic             rollover_flag_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_enable_i) begin
      count_d = (count_q == rollover_val_i) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o         = count_q;
  assign rollover_flag_o = (count_q == rollover_val_i);

endmodule

// File: rtl/usb_rx_timer.sv
// USB receive bit timer: edge-resynchronised phase, mid-bit sample strobe,
// de-stuffed bit/byte counting and line-idle timeout.
module usb_rx_timer
  import usb_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned SAMPLE_POINT = DEF_SAMPLE_POINT,
  parameter int unsigned IDLE_BITS    = DEF_IDLE_BITS
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx_en,
  input  logic       rx_rst,
  input  logic       d_edge,
  input  logic       stuffed,
  output logic       shift_enable,
  output logic       byte_received,
  output logic [3:0] bit_count,
  output logic       timeout
);

  localparam int unsigned PhaseW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdleW     = idle_cnt_width(IDLE_BITS, CLKS_PER_BIT);
  localparam int unsigned IdleLimit = IDLE_BITS * CLKS_PER_BIT;

  localparam logic [PhaseW-1:0] PhaseMax    = PhaseW'(CLKS_PER_BIT - 1);
  localparam logic [PhaseW-1:0] SamplePhase = PhaseW'(SAMPLE_POINT);
  localparam logic [3:0]        BitMax      = 4'(BITS_PER_BYTE - 1);
  localparam logic [IdleW-1:0]  IdleSat     = IdleW'(IdleLimit);
  localparam logic [IdleW-1:0]  IdleFire    = IdleW'(IdleLimit - 1);

  logic [PhaseW-1:0] phase;
  logic [3:0]        bit_cnt;
  logic [IdleW-1:0]  idle_cnt;
  logic              unused_phase_wrap;
  logic              bit_wrap;
  logic              idle_sat;
  logic              sample;
  logic              bit_inc;
  logic              byte_q, byte_d;

  rx_rollover_counter #(
    .Width (PhaseW)
  ) u_phase_cnt (
    .clk             (clk),
    .n_rst           (n_rst),
    .clear_i         (d_edge | rx_rst),
    .count_enable_i  (rx_en),
    .rollover_val_i  (PhaseMax),
    .count_o         (phase),
    .rollover_flag_o (unused_phase_wrap)
  );

  rx_rollover_counter #(
    .Width (4)
  ) u_bit_cnt (
    .clk             (clk),
    .n_rst           (n_rst),
    .clear_i         (rx_rst),
    .count_enable_i  (bit_inc),
    .rollover_val_i  (BitMax),
    .count_o         (bit_cnt),
    .rollover_flag_o (bit_wrap)
  );

  // Rolls over one past the firing value, so gating the enable on the flag saturates it.
  rx_rollover_counter #(
    .Width (IdleW)
  ) u_idle_cnt (
    .clk             (clk),
    .n_rst           (n_rst),
    .clear_i         (d_edge | rx_rst),
    .count_enable_i  (rx_en & ~idle_sat),
    .rollover_val_i  (IdleSat),
    .count_o         (idle_cnt),
    .rollover_flag_o (idle_sat)
  );

  always_comb begin
    sample  = rx_en & ~rx_rst & (phase == SamplePhase);
    bit_inc = sample & ~stuffed;
    byte_d  = bit_inc & bit_wrap;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_q <= 1'b0;
    end else begin
      byte_q <= byte_d;
    end
  end

  assign shift_enable  = sample;
  assign byte_received = byte_q & ~rx_rst;
  assign bit_count     = bit_cnt;
  assign timeout       = rx_en & ~rx_rst & (idle_cnt == IdleFire);

endmodule

// File: tb/tb_usb_rx_timer.sv
// Directed bench for usb_rx_timer with default parameters (8 clks/bit, sample at 3, 8 idle bits).
module tb_usb_rx_timer;

  logic       clk;
  logic       n_rst;
  logic       rx_en;
  logic       rx_rst;
  logic       d_edge;
  logic       stuffed;
  logic       shift_enable;
  logic       byte_received;
  logic [3:0] bit_count;
  logic       timeout;

  int n_checks;
  int n_errors;

  usb_rx_timer u_dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .rx_en         (rx_en),
    .rx_rst        (rx_rst),
    .d_edge        (d_edge),
    .stuffed       (stuffed),
    .shift_enable  (shift_enable),
    .byte_received (byte_received),
    .bit_count     (bit_count),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Synchronous clear with counting disabled, leaving all inputs low.
  task automatic start_clean();
    next_cycle();
    rx_en   = 1'b0;
    rx_rst  = 1'b1;
    d_edge  = 1'b0;
    stuffed = 1'b0;
    next_cycle();
    rx_rst  = 1'b0;
  endtask

  initial begin
    int exp_bc;
    n_checks = 0;
    n_errors = 0;
    n_rst    = 1'b0;
    rx_en    = 1'b0;
    rx_rst   = 1'b0;
    d_edge   = 1'b0;
    stuffed  = 1'b0;

    // Reset state
    repeat (2) next_cycle();
    #1;
    check_val("rst_se", shift_enable, 0);
    check_val("rst_br", byte_received, 0);
    check_val("rst_bc", bit_count, 0);
    check_val("rst_to", timeout, 0);
    n_rst = 1'b1;

    // Free-running byte: strobes at 4,12,..; byte_received at cycle 61
    for (int c = 1; c <= 70; c++) begin
      next_cycle();
      rx_en = 1'b1;
      #1;
      exp_bc = (c <= 4) ? 0 : (((c - 5) / 8 + 1) % 8);
      check_val($sformatf("t1_se_c%0d", c), shift_enable, (c % 8 == 4) ? 1 : 0);
      check_val($sformatf("t1_br_c%0d", c), byte_received, (c == 61) ? 1 : 0);
      check_val($sformatf("t1_bc_c%0d", c), bit_count, exp_bc);
    end

    // Resync: edge at phase 6 of bit 2 (cycle 15) pulls the strobe to cycle 19
    start_clean();
    for (int c = 1; c <= 30; c++) begin
      next_cycle();
      rx_en  = 1'b1;
      d_edge = (c == 15);
      #1;
      check_val($sformatf("t2_se_c%0d", c), shift_enable,
                (c == 4 || c == 12 || c == 19 || c == 27) ? 1 : 0);
      if (c == 16) check_val("t2_bc_c16", bit_count, 2);
      if (c == 20) check_val("t2_bc_c20", bit_count, 3);
    end
    d_edge = 1'b0;

    // Stuffed 7th strobe (cycle 52): count holds at 6, byte slips to cycle 69
    start_clean();
    for (int c = 1; c <= 72; c++) begin
      next_cycle();
      rx_en   = 1'b1;
      stuffed = (c == 52);
      #1;
      check_val($sformatf("t3_br_c%0d", c), byte_received, (c == 69) ? 1 : 0);
      if (c == 53) check_val("t3_bc_c53", bit_count, 6);
      if (c == 61) check_val("t3_bc_c61", bit_count, 7);
      if (c == 69) check_val("t3_bc_c69", bit_count, 0);
    end
    stuffed = 1'b0;

    // Timeout at cycle 64, no repeat; edge at cycle 80 re-arms it for cycle 144
    start_clean();
    for (int c = 1; c <= 150; c++) begin
      next_cycle();
      rx_en  = 1'b1;
      d_edge = (c == 80);
      #1;
      check_val($sformatf("t4_to_c%0d", c), timeout, (c == 64 || c == 144) ? 1 : 0);
    end
    d_edge = 1'b0;

    // rx_rst on the 8th strobe (cycle 60): no byte, counters cleared, strobe at 64
    start_clean();
    for (int c = 1; c <= 66; c++) begin
      next_cycle();
      rx_en  = 1'b1;
      rx_rst = (c == 60);
      #1;
      check_val($sformatf("t5_se_c%0d", c), shift_enable,
                ((c <= 59 && c % 8 == 4) || c == 64) ? 1 : 0);
      check_val($sformatf("t5_br_c%0d", c), byte_received, 0);
      if (c == 61) check_val("t5_bc_c61", bit_count, 0);
    end
    rx_rst = 1'b0;

    // n_rst mid-byte at bit_count=5, then restart
    start_clean();
    for (int c = 1; c <= 37; c++) begin
      next_cycle();
      rx_en = 1'b1;
    end
    #1;
    check_val("t6_bc_pre", bit_count, 5);
    n_rst = 1'b0;
    #1;
    check_val("t6_bc_rst", bit_count, 0);
    check_val("t6_se_rst", shift_enable, 0);
    check_val("t6_br_rst", byte_received, 0);
    check_val("t6_to_rst", timeout, 0);
    for (int c = 1; c <= 13; c++) begin
      next_cycle();
      if (c == 1) n_rst = 1'b1;
      #1;
      check_val($sformatf("t6_se_c%0d", c), shift_enable, (c == 4 || c == 12) ? 1 : 0);
      check_val($sformatf("t6_bc_c%0d", c), bit_count, (c >= 5) ? ((c >= 13) ? 2 : 1) : 0);
    end

    // Disabled: strobe and timeout forced low, counters hold
    rx_en = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      #1;
      check_val($sformatf("t7_se_c%0d", c), shift_enable, 0);
      check_val($sformatf("t7_bc_c%0d", c), bit_count, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
